// File: rtl/sn76489_tone_noise_generator.sv
// SN76489 tone/noise synthesis: three square tones, one LFSR noise, 4-ch mixer.
// Define SN76489_GG_STEREO_EN for Game Gear stereo routing (stereo, sampleLeft/Right).
module sn76489_tone_noise_generator #(
  parameter int          PRESCALE  = 16,
  parameter logic [15:0] LFSR_INIT = 16'h8000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] freq1,
  input  logic [9:0] freq2,
  input  logic [9:0] freq3,
  input  logic [3:0] att1,
  input  logic [3:0] att2,
  input  logic [3:0] att3,
  input  logic [3:0] attNoise,
  input  logic       noiseFeedback,
  input  logic [1:0] noiseFeed,
`ifdef SN76489_GG_STEREO_EN
  input  logic [7:0] stereo,
  output logic [9:0] sampleLeft,
  output logic [9:0] sampleRight,
`endif
  output logic [9:0] sample,
  output logic       sampleValid
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     pre_q;
  logic              tick;

  logic [2:0][9:0]   freq;
  logic [2:0][9:0]   tone_cnt_q;
  logic [2:0][9:0]   tone_cnt_d;
  logic [2:0]        tone_out_q;
  logic [2:0]        tone_out_d;
  logic [2:0]        tone_rel;

  logic [5:0]        noise_per;
  logic [5:0]        noise_cnt_q;
  logic [5:0]        noise_cnt_d;
  logic              noise_clk_q;
  logic              noise_clk_d;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic              lfsr_in;
  logic [2:0]        noise_reg_q;
  logic              noise_chg;

  logic [3:0]        ch_on;
  logic [3:0][3:0]   att;
  logic [9:0]        mix;

  assign freq      = {freq3, freq2, freq1};
  assign att       = {attNoise, att3, att2, att1};
  assign tick      = (pre_q == PW'(PRESCALE - 1));
  assign noise_chg = ({noiseFeedback, noiseFeed} != noise_reg_q);
  assign lfsr_in   = noiseFeedback ? (lfsr_q[0] ^ lfsr_q[3]) : lfsr_q[0];
  assign ch_on     = {lfsr_d[0], tone_out_d};

  function automatic logic [7:0] vol(input logic [3:0] a);
    logic [7:0] v;
    case (a)
      4'd0:    v = 8'd255;
      4'd1:    v = 8'd203;
      4'd2:    v = 8'd161;
      4'd3:    v = 8'd128;
      4'd4:    v = 8'd102;
      4'd5:    v = 8'd81;
      4'd6:    v = 8'd64;
      4'd7:    v = 8'd51;
      4'd8:    v = 8'd40;
      4'd9:    v = 8'd32;
      4'd10:   v = 8'd25;
      4'd11:   v = 8'd20;
      4'd12:   v = 8'd16;
      4'd13:   v = 8'd13;
      4'd14:   v = 8'd10;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // prescaler: free-running divider producing one tick per PRESCALE clocks
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // tone channels: reload-and-toggle half-period counters, forced high for freq<=1
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_out_d = tone_out_q;
    tone_rel   = '0;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (freq[i] <= 10'd1) begin
          tone_out_d[i] = 1'b1;
          tone_cnt_d[i] = '0;
        end else if (tone_cnt_q[i] == 10'd0) begin
          tone_cnt_d[i] = freq[i] - 10'd1;
          tone_out_d[i] = ~tone_out_q[i];
          tone_rel[i]   = 1'b1;
        end else begin
          tone_cnt_d[i] = tone_cnt_q[i] - 10'd1;
        end
      end
    end
  end

  // noise reload value from the shift-rate select
  always_comb begin
    case (noiseFeed)
      2'd0:    noise_per = 6'd15;
      2'd1:    noise_per = 6'd31;
      default: noise_per = 6'd63;
    endcase
  end

  // noise clock and LFSR; a noise-register change overrides tick and shift
  always_comb begin
    noise_cnt_d = noise_cnt_q;
    noise_clk_d = noise_clk_q;
    lfsr_d      = lfsr_q;
    if (tick) begin
      if (noiseFeed == 2'd3) begin
        if (tone_rel[2]) begin
          noise_clk_d = ~noise_clk_q;
        end
      end else if (noise_cnt_q == 6'd0) begin
        noise_cnt_d = noise_per;
        noise_clk_d = ~noise_clk_q;
      end else begin
        noise_cnt_d = noise_cnt_q - 6'd1;
      end
    end
    if (!noise_clk_q && noise_clk_d) begin
      lfsr_d = {lfsr_in, lfsr_q[15:1]};
    end
    if (noise_chg) begin
      lfsr_d      = LFSR_INIT;
      noise_cnt_d = '0;
      noise_clk_d = 1'b0;
    end
  end

  // generator state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      tone_cnt_q  <= '0;
      tone_out_q  <= '1;
      noise_cnt_q <= '0;
      noise_clk_q <= 1'b0;
      lfsr_q      <= LFSR_INIT;
      noise_reg_q <= 3'b000;
    end else begin
      tone_cnt_q  <= tone_cnt_d;
      tone_out_q  <= tone_out_d;
      noise_cnt_q <= noise_cnt_d;
      noise_clk_q <= noise_clk_d;
      lfsr_q      <= lfsr_d;
      noise_reg_q <= {noiseFeedback, noiseFeed};
    end
  end

  // mono mixer over the post-tick channel states
  always_comb begin
    mix = '0;
    for (int i = 0; i < 4; i++) begin
      if (ch_on[i]) begin
        mix = mix + {2'b00, vol(att[i])};
      end
    end
  end

  // sample register, updated one clock after each tick
  always_ff @(posedge clock) begin
    if (reset) begin
      sample      <= '0;
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= tick;
      if (tick) begin
        sample <= mix;
      end
    end
  end

`ifdef SN76489_GG_STEREO_EN
  logic [7:0] stereo_q;
  logic [7:0] stereo_d;
  logic [9:0] mix_l;
  logic [9:0] mix_r;

  assign stereo_d = tick ? stereo : stereo_q;

  // stereo routing mask, captured on each tick
  always_ff @(posedge clock) begin
    if (reset) begin
      stereo_q <= 8'hFF;
    end else begin
      stereo_q <= stereo_d;
    end
  end

  // left/right mixers over the enabled channels only
  always_comb begin
    mix_l = '0;
    mix_r = '0;
    for (int i = 0; i < 4; i++) begin
      if (ch_on[i] && stereo_d[4 + i]) begin
        mix_l = mix_l + {2'b00, vol(att[i])};
      end
      if (ch_on[i] && stereo_d[i]) begin
        mix_r = mix_r + {2'b00, vol(att[i])};
      end
    end
  end

  // stereo sample registers, updated together with sample
  always_ff @(posedge clock) begin
    if (reset) begin
      sampleLeft  <= '0;
      sampleRight <= '0;
    end else if (tick) begin
      sampleLeft  <= mix_l;
      sampleRight <= mix_r;
    end
  end
`endif

endmodule

// File: tb/tb_sn76489_tone_noise_generator.sv
// Scoreboard bench for sn76489_tone_noise_generator.
// A tick-level reference model queues expected samples; a monitor checks them.
module tb_sn76489_tone_noise_generator;

  localparam int PRESCALE = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] freq1, freq2, freq3;
  logic [3:0] att1, att2, att3, attNoise;
  logic       noiseFeedback;
  logic [1:0] noiseFeed;
  logic [9:0] sample;
  logic       sampleValid;
`ifdef SN76489_GG_STEREO_EN
  logic [7:0] stereo = 8'hFF;
  logic [9:0] sampleLeft, sampleRight;
`endif

  sn76489_tone_noise_generator #(
    .PRESCALE (PRESCALE),
    .LFSR_INIT(16'h8000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .freq1        (freq1),
    .freq2        (freq2),
    .freq3        (freq3),
    .att1         (att1),
    .att2         (att2),
    .att3         (att3),
    .attNoise     (attNoise),
    .noiseFeedback(noiseFeedback),
    .noiseFeed    (noiseFeed),
`ifdef SN76489_GG_STEREO_EN
    .stereo       (stereo),
    .sampleLeft   (sampleLeft),
    .sampleRight  (sampleRight),
`endif
    .sample       (sample),
    .sampleValid  (sampleValid)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int n1020 = 0;

  int vol_tab[16] = '{255, 203, 161, 128, 102, 81, 64, 51,
                      40, 32, 25, 20, 16, 13, 10, 0};

  // reference model state (tick-level, plain integers)
  int m_pre;
  int m_half[3];
  bit m_level[3];
  int m_nleft;
  bit m_nclk;
  int m_lfsr;
  int m_prev;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Models one rising clock edge using the inputs currently applied.
  task automatic model_step();
    int f[3];
    int a[3];
    int key;
    int s;
    int nb;
    bit tog3;
    bit was;
    bit tk;
    if (reset) begin
      m_pre = 0;
      for (int i = 0; i < 3; i++) begin
        m_half[i]  = 0;
        m_level[i] = 1'b1;
      end
      m_nleft = 0;
      m_nclk  = 1'b0;
      m_lfsr  = 'h8000;
      m_prev  = 0;
      return;
    end
    f[0] = int'(freq1); f[1] = int'(freq2); f[2] = int'(freq3);
    a[0] = int'(att1);  a[1] = int'(att2);  a[2] = int'(att3);
    key  = int'({noiseFeedback, noiseFeed});
    tk   = (m_pre == PRESCALE - 1);
    m_pre = (m_pre + 1) % PRESCALE;
    tog3 = 1'b0;
    was  = m_nclk;
    if (tk) begin
      for (int i = 0; i < 3; i++) begin
        if (f[i] < 2) begin
          m_level[i] = 1'b1;
          m_half[i]  = 0;
        end else if (m_half[i] == 0) begin
          m_half[i]  = f[i] - 1;
          m_level[i] = !m_level[i];
          if (i == 2) tog3 = 1'b1;
        end else begin
          m_half[i] = m_half[i] - 1;
        end
      end
      if (noiseFeed == 2'd3) begin
        if (tog3) m_nclk = !m_nclk;
      end else if (m_nleft == 0) begin
        m_nleft = (16 << noiseFeed) - 1;
        m_nclk  = !m_nclk;
      end else begin
        m_nleft = m_nleft - 1;
      end
      if (!was && m_nclk) begin
        nb = noiseFeedback ? ((m_lfsr ^ (m_lfsr >> 3)) & 1) : (m_lfsr & 1);
        m_lfsr = (m_lfsr >> 1) | (nb << 15);
      end
    end
    if (key != m_prev) begin
      m_lfsr  = 'h8000;
      m_nleft = 0;
      m_nclk  = 1'b0;
    end
    m_prev = key;
    if (tk) begin
      s = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_level[i]) s += vol_tab[a[i]];
      end
      if ((m_lfsr & 1) != 0) s += vol_tab[attNoise];
      if (s == 1020) n1020++;
      exp_q.push_back(s);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_step();
      @(negedge clock);
    end
  endtask

  function automatic logic [9:0] rand_freq();
    if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
    return 10'($urandom_range(0, 24));
  endfunction

  // monitor: every sampleValid pulse consumes one expected sample
  always @(negedge clock) begin
    int e;
    if (sampleValid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sample", int'(sample), e);
`ifdef SN76489_GG_STEREO_EN
        check("sample_left", int'(sampleLeft), e);
        check("sample_right", int'(sampleRight), e);
`endif
      end
    end
  end

  initial begin
    freq1 = '0; freq2 = '0; freq3 = '0;
    att1 = 4'd15; att2 = 4'd15; att3 = 4'd15; attNoise = 4'd15;
    noiseFeedback = 1'b0;
    noiseFeed = 2'd0;
    reset = 1'b1;
    step(3);
    check("reset_sample", int'(sample), 0);
    check("reset_valid", int'(sampleValid), 0);
    reset = 1'b0;

    // single tone, 10-tick half period
    freq1 = 10'd10; att1 = 4'd0;
    step(PRESCALE * 40);

    // freq 0 and 1 force the output high
    att1 = 4'd15;
    freq2 = 10'd0; att2 = 4'd0;
    step(PRESCALE * 20);
    freq2 = 10'd1;
    step(PRESCALE * 20);

    // periodic noise at the fastest rate
    att2 = 4'd15; freq2 = 10'd0;
    attNoise = 4'd0;
    step(PRESCALE * 560);

    // white noise clocked from tone 3, then a rate change mid-stream
    noiseFeedback = 1'b1; noiseFeed = 2'd3;
    freq3 = 10'd4;
    step(PRESCALE * 200);
    noiseFeed = 2'd2;
    step(PRESCALE * 100);

    // everything at full volume: sum peaks at 1020 when noise bit is high
    noiseFeedback = 1'b0; noiseFeed = 2'd0;
    freq1 = 10'd0; freq2 = 10'd0; freq3 = 10'd0;
    att1 = 4'd0; att2 = 4'd0; att3 = 4'd0; attNoise = 4'd0;
    step(PRESCALE * 520);

    // everything off
    att1 = 4'd15; att2 = 4'd15; att3 = 4'd15; attNoise = 4'd15;
    step(PRESCALE * 30);

    // random register traffic
    for (int k = 0; k < PRESCALE * 1800; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 9))
          0: freq1 = rand_freq();
          1: freq2 = rand_freq();
          2: freq3 = rand_freq();
          3: att1 = 4'($urandom_range(0, 15));
          4: att2 = 4'($urandom_range(0, 15));
          5: att3 = 4'($urandom_range(0, 15));
          6: attNoise = 4'($urandom_range(0, 15));
          7: noiseFeedback = 1'($urandom_range(0, 1));
          8: noiseFeed = 2'($urandom_range(0, 3));
          default: noiseFeed = noiseFeed;
        endcase
      end
      step(1);
    end

    // reset in the middle of a tone half-period
    freq1 = 10'd12; att1 = 4'd0;
    noiseFeedback = 1'b1; noiseFeed = 2'd0; attNoise = 4'd0;
    for (int k = 0; k < PRESCALE * 40 && m_half[0] != 5; k++) step(1);
    reset = 1'b1;
    step(1);
    check("midreset_sample", int'(sample), 0);
    check("midreset_valid", int'(sampleValid), 0);
    reset = 1'b0;
    step(PRESCALE * 60);

    step(2);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
